vx_axi_wdata_router: RTL and testbench

//  Steers AXI write-data (W) beats from NUM_INPUTS masters onto one W channel, in AW-grant order.

---
 rtl/vx_axi_pkg.sv | 28 ++
 rtl/vx_axi_grant_fifo.sv | 45 ++++
 rtl/vx_axi_wdata_router.sv | 150 +++++++++++++++
 tb/tb_vx_axi_wdata_router.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_axi_pkg.sv
// Shared AXI write-path types: burst length, W grant entry and router debug view.
// WGRANT_MAX_INPUTS sizes the grant select field; raise it for wider routers.
package vx_axi_pkg;

    localparam int AXI_LEN_W         = 8;
    localparam int WGRANT_MAX_INPUTS = 2;
    localparam int SEL_W             = (WGRANT_MAX_INPUTS > 1) ? $clog2(WGRANT_MAX_INPUTS) : 1;

    typedef logic [AXI_LEN_W-1:0] axi_len_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        axi_len_t         len;
    } wgrant_t;

    typedef enum logic {
        W_IDLE   = 1'b0,
        W_STREAM = 1'b1
    } wstate_e;

    typedef struct packed {
        wstate_e          state;
        axi_len_t         beat_cnt;
        logic [SEL_W-1:0] cur_sel;
        axi_len_t         cur_len;
    } router_dbg_t;

endpackage

// File: rtl/vx_axi_grant_fifo.sv
// Grant queue for the W router: DEPTH-entry FIFO of wgrant_t with wrap-bit pointers.
// Head entry is visible on dout whenever empty is low.
module vx_axi_grant_fifo
    import vx_axi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wgrant_t                  din,
    input  logic                     pop,
    output wgrant_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    wgrant_t        mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read behind a valid pointer.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vx_axi_wdata_router.sv
// Routes W beats from NUM_INPUTS masters onto one W channel in AW-grant order.
// VX_AXI_WLAST_CHECK_EN: generate wlast from awlen and flag mismatching s_wlast.
module vx_axi_wdata_router
    import vx_axi_pkg::*;
#(
    parameter int NUM_INPUTS  = 2,
    parameter int DATA_WIDTH  = 512,
    parameter int GRANT_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             grant_valid,
    output logic                             grant_ready,
    input  logic [SEL_W-1:0]                 grant_sel,
    input  logic [AXI_LEN_W-1:0]             grant_len,
    input  logic [NUM_INPUTS-1:0]            s_wvalid,
    output logic [NUM_INPUTS-1:0]            s_wready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_INPUTS*DATA_WIDTH/8-1:0] s_wstrb,
    input  logic [NUM_INPUTS-1:0]            s_wlast,
    output logic                             m_wvalid,
    input  logic                             m_wready,
    output logic [DATA_WIDTH-1:0]            m_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_wstrb,
    output logic                             m_wlast,
    output logic                             err_wlast,
    output router_dbg_t                      dbg
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, ready may depend on valid.
    localparam int STRB_W = DATA_WIDTH / 8;

    wgrant_t                   grant_in;
    wgrant_t                   head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(GRANT_DEPTH):0] fifo_count;
    logic                      grant_push;
    logic                      head_pop;

    wstate_e                   state;
    wstate_e                   state_next;
    axi_len_t                  beat_cnt;
    logic                      streaming;
    logic                      beat_hs;
    logic                      last_beat;

    logic                      sel_valid;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic [STRB_W-1:0]         sel_strb;
    logic                      sel_last;

    assign grant_ready = !fifo_full && !reset;
    assign grant_push  = grant_valid && grant_ready;
    assign grant_in    = '{sel: grant_sel, len: grant_len};

    vx_axi_grant_fifo #(
        .DEPTH (GRANT_DEPTH)
    ) u_grant_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (grant_push),
        .din   (grant_in),
        .pop   (head_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_strb  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (head.sel == SEL_W'(i)) begin
                sel_valid = s_wvalid[i];
                sel_data  = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = s_wstrb[i*STRB_W +: STRB_W];
                sel_last  = s_wlast[i];
            end
        end
    end

    assign streaming = (state == W_STREAM);
    assign m_wvalid  = streaming && sel_valid;
    assign m_wdata   = streaming ? sel_data : '0;
    assign m_wstrb   = streaming ? sel_strb : '0;
    assign beat_hs   = m_wvalid && m_wready;
    assign head_pop  = beat_hs && last_beat;

    always_comb begin
        s_wready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            s_wready[i] = streaming && (head.sel == SEL_W'(i)) && m_wready;
        end
    end

`ifdef VX_AXI_WLAST_CHECK_EN
    logic len_hit;
    logic err_q;

    assign len_hit   = (beat_cnt == head.len);
    assign last_beat = len_hit;
    assign m_wlast   = streaming && len_hit;
    assign err_wlast = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (beat_hs && (sel_last != len_hit)) begin
            err_q <= 1'b1;
        end
    end
`else
    assign last_beat = sel_last;
    assign m_wlast   = streaming && sel_last;
    assign err_wlast = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= W_IDLE;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            if (beat_hs) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    // Drop to IDLE only when the popped head was the last queued grant.
    always_comb begin
        state_next = state;
        case (state)
            W_IDLE: begin
                if (grant_push) state_next = W_STREAM;
            end
            W_STREAM: begin
                if (head_pop && (fifo_count == ($clog2(GRANT_DEPTH)+1)'(1)) && !grant_push)
                    state_next = W_IDLE;
            end
            default: state_next = W_IDLE;
        endcase
    end

    assign dbg = '{state: state, beat_cnt: beat_cnt, cur_sel: head.sel, cur_len: head.len};

endmodule

// File: tb/tb_vx_axi_wdata_router.sv
// Directed scoreboard bench for vx_axi_wdata_router (2 inputs, 32-bit data).
module tb_vx_axi_wdata_router;
    import vx_axi_pkg::*;

    localparam int NI = 2;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int GD = 4;
    localparam int BW = DW + SW + 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 grant_valid = 1'b0;
    logic                 grant_ready;
    logic [SEL_W-1:0]     grant_sel = '0;
    logic [AXI_LEN_W-1:0] grant_len = '0;
    logic [NI-1:0]        s_wvalid;
    logic [NI-1:0]        s_wready;
    logic [NI*DW-1:0]     s_wdata;
    logic [NI*SW-1:0]     s_wstrb;
    logic [NI-1:0]        s_wlast;
    logic                 m_wvalid;
    logic                 m_wready = 1'b0;
    logic [DW-1:0]        m_wdata;
    logic [SW-1:0]        m_wstrb;
    logic                 m_wlast;
    logic                 err_wlast;
    router_dbg_t          dbg;

    vx_axi_wdata_router #(
        .NUM_INPUTS  (NI),
        .DATA_WIDTH  (DW),
        .GRANT_DEPTH (GD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_sel   (grant_sel),
        .grant_len   (grant_len),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_wlast     (s_wlast),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wlast     (m_wlast),
        .err_wlast   (err_wlast),
        .dbg         (dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic [BW-1:0] exp_q[$];
    int hs_cyc[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        grant_valid = 1'b0;
        m_wready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        exp_q.delete();
        hs_cyc.delete();
    endtask

    // ---------------- upstream sources ----------------
    logic [NI-1:0] src_en = '0;
    int src_blen[NI] = '{1, 1};
    int src_k[NI] = '{0, 0};
    int src_b[NI] = '{0, 0};

    function automatic logic [DW-1:0] mk_data(input int i, input int k);
        return 32'hD000_0000 + DW'(i * 4096) + DW'(k);
    endfunction

    function automatic logic [SW-1:0] mk_strb(input int k);
        return SW'(1 << (k % 4));
    endfunction

    task automatic drive_src();
        for (int i = 0; i < NI; i++) begin
            s_wvalid[i]           = src_en[i];
            s_wdata[i*DW +: DW]   = mk_data(i, src_k[i]);
            s_wstrb[i*SW +: SW]   = mk_strb(src_k[i]);
            s_wlast[i]            = (src_b[i] == src_blen[i] - 1);
        end
    endtask

    initial begin
        logic [NI-1:0] acc;
        drive_src();
        forever begin
            @(negedge clk);
            acc = s_wvalid & s_wready;
            @(posedge clk);
            #2;
            for (int i = 0; i < NI; i++) begin
                if (reset) begin
                    src_k[i] = 0;
                    src_b[i] = 0;
                end else if (acc[i]) begin
                    src_k[i] = src_k[i] + 1;
                    src_b[i] = (src_b[i] == src_blen[i] - 1) ? 0 : src_b[i] + 1;
                end
            end
            drive_src();
        end
    end

    task automatic exp_beat(input int i, input int k, input logic last);
        exp_q.push_back({mk_data(i, k), mk_strb(k), last});
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && m_wvalid && m_wready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got=%0h expected=none (t=%0t)",
                             {m_wdata, m_wstrb, m_wlast}, $time);
                end else begin
                    check("beat", 64'({m_wdata, m_wstrb, m_wlast}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_grant(input int sel, input int len);
        logic r;
        logic done = 1'b0;
        grant_valid = 1'b1;
        grant_sel   = SEL_W'(sel);
        grant_len   = AXI_LEN_W'(len);
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            r = grant_ready;
            tick();
            if (r) done = 1'b1;
        end
        grant_valid = 1'b0;
        if (!done) check("grant_accept_timeout", 64'(done), 64'(1));
    endtask

    task automatic wait_idle(input string name, output logic [NI-1:0] rdy_or);
        logic done = 1'b0;
        rdy_or = '0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            rdy_or = rdy_or | s_wready;
            if (dbg.state == W_IDLE && exp_q.size() == 0) done = 1'b1;
        end
        check(name, 64'(done), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    initial begin
        logic [NI-1:0] rdy;
        logic early;

        // reset state
        @(negedge clk);
        check("rst_grant_ready", 64'(grant_ready), 64'(0));
        check("rst_s_wready", 64'(s_wready), 64'(0));
        check("rst_m_wvalid", 64'(m_wvalid), 64'(0));
        reset_all();
        @(negedge clk);
        check("rst_state", 64'(dbg.state), 64'(W_IDLE));
        check("rst_grant_ready_rel", 64'(grant_ready), 64'(1));
        check("rst_err", 64'(err_wlast), 64'(0));

        // 1: single grant sel=1 len=3
        reset_all();
        src_blen[0] = 1; src_blen[1] = 4; src_en = 2'b11; m_wready = 1'b1;
        for (int k = 0; k < 4; k++) exp_beat(1, k, k == 3);
        send_grant(1, 3);
        wait_idle("t1_done", rdy);
        check("t1_wready0", 64'(rdy[0]), 64'(0));
        check("t1_empty", 64'(grant_ready), 64'(1));
        check("t1_beatcnt", 64'(dbg.beat_cnt), 64'(0));

        // 2: back-to-back grants, no bubble
        reset_all();
        src_blen[0] = 2; src_blen[1] = 1; src_en = 2'b11; m_wready = 1'b1;
        exp_beat(0, 0, 1'b0);
        exp_beat(0, 1, 1'b1);
        exp_beat(1, 0, 1'b1);
        send_grant(0, 1);
        send_grant(1, 0);
        wait_idle("t2_done", rdy);
        check("t2_nbeats", 64'(hs_cyc.size()), 64'(3));
        if (hs_cyc.size() == 3) check("t2_no_bubble", 64'(hs_cyc[2] - hs_cyc[0]), 64'(2));
        check("t2_err", 64'(err_wlast), 64'(0));

        // 3: W before AW
        reset_all();
        src_blen[0] = 1; src_en = 2'b01; m_wready = 1'b1;
        early = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (s_wready[0] || m_wvalid) early = 1'b1;
        end
        check("t3_stalled", 64'(early), 64'(0));
        exp_beat(0, 0, 1'b1);
        tick();
        send_grant(0, 0);
        @(negedge clk);
        check("t3_latency", 64'(m_wvalid), 64'(1));
        wait_idle("t3_done", rdy);

        // 4: fill the queue while stalled
        reset_all();
        src_blen[0] = 1; src_blen[1] = 1; src_en = 2'b11; m_wready = 1'b0;
        exp_beat(0, 0, 1'b1);
        exp_beat(1, 0, 1'b1);
        exp_beat(0, 1, 1'b1);
        exp_beat(1, 1, 1'b1);
        send_grant(0, 0);
        send_grant(1, 0);
        send_grant(0, 0);
        send_grant(1, 0);
        @(negedge clk);
        check("t4_full", 64'(grant_ready), 64'(0));
        tick();
        m_wready = 1'b1;
        @(negedge clk);
        check("t4_still_full", 64'(grant_ready), 64'(0));
        @(negedge clk);
        check("t4_ready_rise", 64'(grant_ready), 64'(1));
        wait_idle("t4_done", rdy);

        // 5: wlast mismatch (grant len=1, source ends burst after 1 beat)
        reset_all();
        src_blen[0] = 1; src_en = 2'b01; m_wready = 1'b1;
`ifdef VX_AXI_WLAST_CHECK_EN
        exp_beat(0, 0, 1'b0);
        exp_beat(0, 1, 1'b1);
        send_grant(0, 1);
        @(negedge clk);
        check("t5_err_before", 64'(err_wlast), 64'(0));
        @(negedge clk);
        check("t5_err_set", 64'(err_wlast), 64'(1));
        wait_idle("t5_done", rdy);
        check("t5_err_sticky", 64'(err_wlast), 64'(1));
`else
        exp_beat(0, 0, 1'b1);
        send_grant(0, 1);
        wait_idle("t5_done", rdy);
        check("t5_err_tied", 64'(err_wlast), 64'(0));
        check("t5_beatcnt", 64'(dbg.beat_cnt), 64'(0));
`endif

        // 6: reset mid-burst
        reset_all();
        src_blen[1] = 4; src_en = 2'b10; m_wready = 1'b1;
        exp_beat(1, 0, 1'b0);
        exp_beat(1, 1, 1'b0);
        send_grant(1, 3);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t6_m_wvalid", 64'(m_wvalid), 64'(0));
        check("t6_s_wready", 64'(s_wready), 64'(0));
        check("t6_grant_ready", 64'(grant_ready), 64'(0));
        check("t6_m_wlast", 64'(m_wlast), 64'(0));
        check("t6_partial", 64'(exp_q.size()), 64'(0));
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_state", 64'(dbg.state), 64'(W_IDLE));
        check("t6_err", 64'(err_wlast), 64'(0));
        check("t6_empty", 64'(grant_ready), 64'(1));
        for (int k = 0; k < 4; k++) exp_beat(1, k, k == 3);
        tick();
        send_grant(1, 3);
        wait_idle("t6_done", rdy);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
